sliced_logic_unit: RTL and testbench

- Multi-cycle bitwise logic unit for the multiple-cycle datapath.
- Generalises the single-bit AND gate to a WIDTH-bit, four-operation unit (AND/OR/XOR/NOR).
- Processes SLICE bits per clock under a start/busy/done handshake, so bitwise ops share the slot timing of the multi-cycle ALU.
- Outputs a registered result and a zero flag.

---
 rtl/sliced_logic_unit_pkg.sv | 21 ++
 rtl/slice_logic.sv | 23 ++
 rtl/sliced_logic_unit.sv | 112 +++++++++++
 tb/tb_sliced_logic_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sliced_logic_unit_pkg.sv
// rtl/sliced_logic_unit_pkg.sv - shared op and FSM encodings for the multi-cycle ALU slice units
package sliced_logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int slice_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slice_logic.sv
// rtl/slice_logic.sv - combinational SLICE-bit AND/OR/XOR/NOR
module slice_logic
    import sliced_logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  op_e              op,
    output logic [SLICE-1:0] z
);

    always_comb begin
        z = '0;
        unique case (op)
            OP_AND: z = x & y;
            OP_OR:  z = x | y;
            OP_XOR: z = x ^ y;
            OP_NOR: z = ~(x | y);
        endcase
    end

endmodule

// File: rtl/sliced_logic_unit.sv
// rtl/sliced_logic_unit.sv - multi-cycle WIDTH-bit logic unit processing SLICE bits per clock
module sliced_logic_unit
    import sliced_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = slice_cnt_width(N);

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("sliced_logic_unit: WIDTH must be a multiple of SLICE");
    end

    state_e                    state;
    state_e                    state_nxt;
    logic                      accept;
    logic                      last;
    logic [CNT_W-1:0]          idx;
    logic [N-1:0][SLICE-1:0]   a_r;
    logic [N-1:0][SLICE-1:0]   b_r;
    logic [N-1:0][SLICE-1:0]   shadow;
    logic [N-1:0][SLICE-1:0]   acc_next;
    op_e                       op_r;
    logic [SLICE-1:0]          slice_z;

    assign last = (idx == CNT_W'(N - 1));
    assign busy = (state == S_RUN);

    slice_logic #(.SLICE(SLICE)) u_slice (
        .x  (a_r[idx]),
        .y  (b_r[idx]),
        .op (op_r),
        .z  (slice_z)
    );

    always_comb begin
        acc_next      = shadow;
        acc_next[idx] = slice_z;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // result/zero only move on the completing edge; they hold through start and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_AND;
            shadow <= '0;
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op_e'(op);
                idx  <= '0;
            end else if (state == S_RUN) begin
                shadow <= acc_next;
                if (last) begin
                    idx    <= '0;
                    result <= acc_next;
                    zero   <= (acc_next == '0);
                    done   <= 1'b1;
                end else begin
                    idx <= idx + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sliced_logic_unit.sv
// tb/tb_sliced_logic_unit.sv - self-checking bench for sliced_logic_unit (SLICE 8, 32 and 4)
module tb_sliced_logic_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;

    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [2:0]  zero_w;
    logic [31:0] result_w [3];

    int n_tests = 0;
    int n_fail  = 0;

    int nsl [3] = '{4, 1, 8};

    bit          m_busy [3];
    bit          m_done [3];
    int          m_rem  [3];
    logic [31:0] m_res  [3];
    logic [31:0] m_pend [3];

    int first_d [3];
    int cnt_d   [3];
    int bcnt0;

    sliced_logic_unit #(.WIDTH(32), .SLICE(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]), .zero(zero_w[0])
    );
    sliced_logic_unit #(.WIDTH(32), .SLICE(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]), .zero(zero_w[1])
    );
    sliced_logic_unit #(.WIDTH(32), .SLICE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy_w[2]), .done(done_w[2]), .result(result_w[2]), .zero(zero_w[2])
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each accepted request completes N edges later with the whole-word result.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_rem[i]  = 0;
                m_res[i]  = '0;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_res[i]  = m_pend[i];
                    end
                end else if (start) begin
                    m_busy[i] = 1'b1;
                    m_rem[i]  = nsl[i];
                    m_pend[i] = ref_op(op, a, b);
                end
            end
            chk($sformatf("model_busy%0d", i), busy_w[i], m_busy[i]);
            chk($sformatf("model_done%0d", i), done_w[i], m_done[i]);
            chk($sformatf("model_result%0d", i), result_w[i], m_res[i]);
            chk($sformatf("model_zero%0d", i), zero_w[i], (m_res[i] == 0));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic observe(input int cycles);
        bcnt0 = busy_w[0] ? 1 : 0;
        for (int d = 0; d < 3; d++) begin
            first_d[d] = 0;
            cnt_d[d]   = 0;
        end
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (busy_w[0]) bcnt0++;
            for (int d = 0; d < 3; d++) begin
                if (done_w[d]) begin
                    cnt_d[d]++;
                    if (first_d[d] == 0) first_d[d] = c;
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_busy%0d", d), busy_w[d], 0);
            chk($sformatf("reset_done%0d", d), done_w[d], 0);
            chk($sformatf("reset_result%0d", d), result_w[d], 0);
            chk($sformatf("reset_zero%0d", d), zero_w[d], 1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'd0, 32'hF0F0_1234, 32'hFF00_FF00);
        chk("and_busy_after_start", busy_w[0], 1);
        observe(12);
        chk("and_busy_cycles", bcnt0, 4);
        chk("and_latency_s8", first_d[0], 4);
        chk("and_latency_s32", first_d[1], 1);
        chk("and_latency_s4", first_d[2], 8);
        chk("and_done_count", cnt_d[0], 1);
        chk("and_result_s8", result_w[0], 32'hF000_1200);
        chk("and_zero_s8", zero_w[0], 0);
        chk("and_result_s4", result_w[2], 32'hF000_1200);
        chk("and_result_s32", result_w[1], 32'hF000_1200);

        issue(2'd1, 32'h0000_00FF, 32'h8000_0000);
        observe(12);
        chk("or_result", result_w[0], 32'h8000_00FF);
        chk("or_zero", zero_w[0], 0);
        issue(2'd3, 32'hFFFF_FFFF, 32'h0000_0000);
        observe(12);
        chk("nor_result", result_w[0], 32'h0000_0000);
        chk("nor_zero", zero_w[0], 1);

        start = 1'b1; op = 2'd2; a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF;
        @(negedge clk);
        a = 32'h1234_5678; op = 2'd0;
        @(negedge clk);
        start = 1'b0;
        observe(12);
        chk("iso_done_count", cnt_d[0], 1);
        chk("iso_done_count_s4", cnt_d[2], 1);
        chk("iso_result", result_w[0], 0);
        chk("iso_zero", zero_w[0], 1);

        issue(2'd1, 32'h0000_00FF, 32'h8000_0000);
        for (int c = 0; c < 12 && !done_w[0]; c++) @(negedge clk);
        chk("b2b_first_done", done_w[0], 1);
        issue(2'd0, 32'hFFFF_0000, 32'h0F0F_0F0F);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("b2b_hold_result", result_w[0], 32'h8000_00FF);
            chk("b2b_no_early_done", done_w[0], 0);
        end
        @(negedge clk);
        chk("b2b_second_done", done_w[0], 1);
        chk("b2b_result", result_w[0], 32'h0F0F_0000);
        observe(12);

        issue(2'd1, 32'h0000_000F, 32'h0000_00F0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_done", done_w[0], 0);
        chk("midrst_result", result_w[0], 0);
        chk("midrst_zero", zero_w[0], 1);
        observe(3);
        chk("midrst_no_done_in_reset", cnt_d[0], 0);
        rst_n = 1'b1;
        observe(8);
        chk("midrst_no_done_after", cnt_d[0], 0);
        issue(2'd1, 32'h0000_0001, 32'h0000_0002);
        observe(12);
        chk("post_rst_or_s8", result_w[0], 32'h0000_0003);
        chk("post_rst_or_s32", result_w[1], 32'h0000_0003);
        chk("post_rst_or_s4", result_w[2], 32'h0000_0003);

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            start = ($urandom_range(2) == 0);
            op    = 2'($urandom_range(3));
            a     = $urandom;
            b     = $urandom;
            if ($urandom_range(5) == 0) b = a;
            if ($urandom_range(5) == 0) b = ~a;
            rst_n = ($urandom_range(79) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        observe(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
